// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: queue entry layout and RV32I major-opcode constants.
package fetch_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        illegal;
   } fetch_entry_t;

   localparam logic [6:0] OPC_LUI      = 7'h37;
   localparam logic [6:0] OPC_AUIPC    = 7'h17;
   localparam logic [6:0] OPC_JAL      = 7'h6f;
   localparam logic [6:0] OPC_JALR     = 7'h67;
   localparam logic [6:0] OPC_BRANCH   = 7'h63;
   localparam logic [6:0] OPC_LOAD     = 7'h03;
   localparam logic [6:0] OPC_STORE    = 7'h23;
   localparam logic [6:0] OPC_OP_IMM   = 7'h13;
   localparam logic [6:0] OPC_OP       = 7'h33;
   localparam logic [6:0] OPC_MISC_MEM = 7'h0f;
   localparam logic [6:0] OPC_SYSTEM   = 7'h73;

   function automatic logic is_legal_opcode(input logic [6:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
         OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through circular buffer of fetch entries with synchronous clear.
module fetch_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [31:0]
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   clear,
   input  logic                   push,
   input  T                       push_data,
   input  logic                   pop,
   output T                       head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [AW:0]    count_reg;
   logic           do_push;
   logic           do_pop;

   // Clear wins over both push and pop: a flushed cycle leaves nothing behind.
   assign do_push = push && !clear;
   assign do_pop  = pop && (count_reg != '0);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (srst || clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: sequential PC generation, imem request/response tracking and a small {pc, instr} queue.
// Optional per-entry illegal-opcode flag enabled by defining FETCH_ILLEGAL_CHECK_EN.
module instr_fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   output logic                   o_imem_req,
   output logic [31:0]            o_imem_addr,
   input  logic [31:0]            i_imem_rdata,
   input  logic                   i_redirect,
   input  logic [31:0]            i_redirect_pc,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [31:0]            o_pc,
   output logic [31:0]            o_instr,
   output logic                   o_illegal,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int CW = $clog2(DEPTH) + 1;

`ifdef FETCH_ILLEGAL_CHECK_EN
   typedef fetch_entry_t entry_t;
`else
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;
`endif

   logic [31:0]   pc_reg;
   logic [31:0]   inflight_pc_reg;
   logic          inflight_reg;
   logic [CW-1:0] count;
   logic          issue;
   logic          push;
   logic          valid;
   entry_t        push_entry;
   entry_t        head_entry;

   // The in-flight request already owns a queue slot, so pushes can never overflow.
   assign issue = !i_rst && !i_redirect &&
                  (({1'b0, count} + {{CW{1'b0}}, inflight_reg}) < (CW+1)'(DEPTH));
   assign push  = inflight_reg && !i_redirect;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_reg          <= RESET_PC;
         inflight_pc_reg <= '0;
         inflight_reg    <= 1'b0;
      end else if (i_redirect) begin
         pc_reg       <= i_redirect_pc & 32'hFFFF_FFFC;
         inflight_reg <= 1'b0;
      end else if (issue) begin
         pc_reg          <= pc_reg + 32'd4;
         inflight_pc_reg <= pc_reg;
         inflight_reg    <= 1'b1;
      end else begin
         inflight_reg <= 1'b0;
      end
   end

   always_comb begin
      push_entry       = '0;
      push_entry.pc    = inflight_pc_reg;
      push_entry.instr = i_imem_rdata;
`ifdef FETCH_ILLEGAL_CHECK_EN
      push_entry.illegal = !is_legal_opcode(i_imem_rdata[6:0]);
`endif
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk       (i_clk),
      .srst      (i_rst),
      .clear     (i_redirect),
      .push      (push),
      .push_data (push_entry),
      .pop       (i_ready && valid),
      .head      (head_entry),
      .count     (count)
   );

   assign valid       = (count != '0);
   assign o_valid     = valid;
   assign o_count     = count;
   assign o_imem_req  = issue;
   assign o_imem_addr = pc_reg;
   // Head fields read as zero while empty so the decoder never sees stale entries.
   assign o_pc        = valid ? head_entry.pc    : 32'h0;
   assign o_instr     = valid ? head_entry.instr : 32'h0;
`ifdef FETCH_ILLEGAL_CHECK_EN
   assign o_illegal   = valid ? head_entry.illegal : 1'b0;
`else
   assign o_illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: expected {pc, instr, illegal} stream queued per fetch restart.
module tb_instr_fetch_queue;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic [31:0] i_imem_rdata = '0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_pc;
   logic [31:0] o_instr;
   logic        o_illegal;
   logic [2:0]  o_count;

   logic        w_req, w_valid, w_illegal;
   logic [31:0] w_addr, w_pc, w_instr;
   logic [31:0] w_rdata = '0;
   logic [2:0]  w_count;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];

`ifdef FETCH_ILLEGAL_CHECK_EN
   localparam logic ILL_7F = 1'b1;
`else
   localparam logic ILL_7F = 1'b0;
`endif

   always #5 clk = ~clk;

   instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .i_clk(clk), .i_rst(i_rst), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_rdata(i_imem_rdata), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
      .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_instr(o_instr),
      .o_illegal(o_illegal), .o_count(o_count)
   );

   instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .i_clk(clk), .i_rst(i_rst), .o_imem_req(w_req), .o_imem_addr(w_addr),
      .i_imem_rdata(w_rdata), .i_redirect(1'b0), .i_redirect_pc(32'h0),
      .o_valid(w_valid), .i_ready(1'b1), .o_pc(w_pc), .o_instr(w_instr),
      .o_illegal(w_illegal), .o_count(w_count)
   );

   // Instruction memory model: the address itself, except a 0x1000 page of OP / bad opcodes.
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      if (a[31:12] == 20'h00001) return a[2] ? 32'h0000_007F : 32'h0000_0033;
      return a;
   endfunction

   function automatic logic exp_ill(input logic [31:0] w);
`ifdef FETCH_ILLEGAL_CHECK_EN
      case (w[6:0])
         7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73: return 1'b0;
         default: return 1'b1;
      endcase
`else
      return 1'b0 & w[0];
`endif
   endfunction

   always @(posedge clk) begin
      i_imem_rdata <= imem_word(o_imem_addr);
      w_rdata      <= imem_word(w_addr);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic load_exp(input logic [31:0] start);
      exp_q.delete();
      for (int k = 0; k < 32; k++) exp_q.push_back(start + 32'(k * 4));
   endtask

   task automatic do_reset();
      next_cycle();
      i_rst = 1'b1;
      i_redirect = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_reset();
      logic [31:0] e;
      i_ready = 1'b1;
      do_reset();
      #1;
      total++;
      if (o_count !== 3'd0 || o_valid !== 1'b0 || o_imem_req !== 1'b0 || o_pc !== 32'h0 || o_instr !== 32'h0 || o_illegal !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got cnt=%0d valid=%b req=%b pc=%h instr=%h ill=%b, expected all zero", o_count, o_valid, o_imem_req, o_pc, o_instr, o_illegal);
      end
      load_exp(32'h0);
      for (int c = 0; c < 14; c++) begin
         next_cycle();
         i_rst = 1'b0;
         #1;
         if (c < 3) begin
            total++;
            if (o_imem_req !== 1'b1 || o_imem_addr !== 32'(c * 4)) begin
               bad++;
               $display("FAIL t1_issue c=%0d got req=%b addr=%h, expected req=1 addr=%h", c, o_imem_req, o_imem_addr, 32'(c * 4));
            end
            total++;
            if (o_valid !== (c == 2)) begin
               bad++;
               $display("FAIL t1_latency c=%0d got valid=%b, expected %b", c, o_valid, (c == 2));
            end
         end
         if (o_valid && i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL t1_pop got pc=%h, expected no entry", o_pc);
            end else begin
               e = exp_q.pop_front();
               if (o_pc !== e || o_instr !== imem_word(e) || o_illegal !== exp_ill(imem_word(e))) begin
                  bad++;
                  $display("FAIL t1_pop got pc=%h instr=%h ill=%b, expected pc=%h instr=%h ill=%b", o_pc, o_instr, o_illegal, e, imem_word(e), exp_ill(imem_word(e)));
               end else $display("t1 pop pc=%h instr=%h", o_pc, o_instr);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] e;
      i_ready = 1'b0;
      do_reset();
      load_exp(32'h0);
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         i_rst = 1'b0;
         #1;
         if (c >= 4) begin
            total++;
            if (o_imem_req !== 1'b0) begin
               bad++;
               $display("FAIL t2_full_stop c=%0d got req=%b, expected 0", c, o_imem_req);
            end
         end
         if (c >= 2) begin
            total++;
            if (o_valid !== 1'b1 || o_pc !== 32'h0) begin
               bad++;
               $display("FAIL t2_head_stable c=%0d got valid=%b pc=%h, expected valid=1 pc=0", c, o_valid, o_pc);
            end
         end
      end
      total++;
      if (o_count !== 3'd4) begin
         bad++;
         $display("FAIL t2_count_sat got %0d, expected 4", o_count);
      end
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         i_ready = 1'b1;
         #1;
         if (c < 6) begin
            total++;
            if (o_valid !== 1'b1) begin
               bad++;
               $display("FAIL t2_no_gap c=%0d got valid=%b, expected 1", c, o_valid);
            end
         end
         if (o_valid && i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL t2_pop got pc=%h, expected no entry", o_pc);
            end else begin
               e = exp_q.pop_front();
               if (o_pc !== e || o_instr !== imem_word(e) || o_illegal !== exp_ill(imem_word(e))) begin
                  bad++;
                  $display("FAIL t2_pop got pc=%h instr=%h ill=%b, expected pc=%h instr=%h ill=%b", o_pc, o_instr, o_illegal, e, imem_word(e), exp_ill(imem_word(e)));
               end else $display("t2 pop pc=%h instr=%h", o_pc, o_instr);
            end
         end
      end
   endtask

   task automatic test_redirect();
      logic [31:0] e;
      i_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         i_rst = 1'b0;
      end
      next_cycle();
      i_redirect = 1'b1;
      i_redirect_pc = 32'h0000_0103;
      #1;
      total++;
      if (o_imem_req !== 1'b0 || o_count !== 3'd3) begin
         bad++;
         $display("FAIL t3_redirect_cycle got req=%b cnt=%0d, expected req=0 cnt=3", o_imem_req, o_count);
      end
      load_exp(32'h0000_0100);
      for (int k = 1; k <= 12; k++) begin
         next_cycle();
         i_redirect = 1'b0;
         i_ready = 1'b1;
         #1;
         if (k == 1) begin
            total++;
            if (o_valid !== 1'b0 || o_count !== 3'd0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin
               bad++;
               $display("FAIL t3_flush got valid=%b cnt=%0d req=%b addr=%h, expected 0 0 1 00000100", o_valid, o_count, o_imem_req, o_imem_addr);
            end
         end
         if (k == 2 || k == 3) begin
            total++;
            if (o_valid !== (k == 3)) begin
               bad++;
               $display("FAIL t3_latency k=%0d got valid=%b, expected %b", k, o_valid, (k == 3));
            end
         end
         if (o_valid && i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL t3_pop got pc=%h, expected no entry", o_pc);
            end else begin
               e = exp_q.pop_front();
               if (o_pc !== e || o_instr !== imem_word(e) || o_illegal !== exp_ill(imem_word(e))) begin
                  bad++;
                  $display("FAIL t3_pop got pc=%h instr=%h ill=%b, expected pc=%h instr=%h ill=%b", o_pc, o_instr, o_illegal, e, imem_word(e), exp_ill(imem_word(e)));
               end else $display("t3 pop pc=%h instr=%h", o_pc, o_instr);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      i_ready = 1'b1;
      do_reset();
      load_exp(32'h0);
      for (int c = 0; c < 9; c++) begin
         next_cycle();
         i_rst = 1'b0;
         if (c == 7) begin
            i_redirect = 1'b1;
            i_redirect_pc = 32'h0000_0200;
         end
         if (c == 8) i_redirect_pc = 32'h0000_0300;
         #1;
         if (c >= 7) begin
            total++;
            if (o_imem_req !== 1'b0) begin
               bad++;
               $display("FAIL t4_no_issue c=%0d got req=%b, expected 0", c, o_imem_req);
            end
         end
         if (c == 8) begin
            total++;
            if (o_valid !== 1'b0) begin
               bad++;
               $display("FAIL t4_flushed got valid=%b, expected 0", o_valid);
            end
         end
         if (o_valid && i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL t4_pop got pc=%h, expected no entry", o_pc);
            end else begin
               e = exp_q.pop_front();
               if (o_pc !== e || o_instr !== imem_word(e) || o_illegal !== exp_ill(imem_word(e))) begin
                  bad++;
                  $display("FAIL t4_pop got pc=%h instr=%h ill=%b, expected pc=%h instr=%h ill=%b", o_pc, o_instr, o_illegal, e, imem_word(e), exp_ill(imem_word(e)));
               end else $display("t4 pop pc=%h instr=%h", o_pc, o_instr);
            end
         end
      end
      load_exp(32'h0000_0300);
      for (int k = 1; k <= 12; k++) begin
         next_cycle();
         i_redirect = 1'b0;
         #1;
         if (k == 1) begin
            total++;
            if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h300) begin
               bad++;
               $display("FAIL t4_restart got req=%b addr=%h, expected req=1 addr=00000300", o_imem_req, o_imem_addr);
            end
         end
         if (o_valid && i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL t4_pop got pc=%h, expected no entry", o_pc);
            end else begin
               e = exp_q.pop_front();
               if (o_pc !== e || o_instr !== imem_word(e) || o_illegal !== exp_ill(imem_word(e))) begin
                  bad++;
                  $display("FAIL t4_pop got pc=%h instr=%h ill=%b, expected pc=%h instr=%h ill=%b", o_pc, o_instr, o_illegal, e, imem_word(e), exp_ill(imem_word(e)));
               end else $display("t4 pop pc=%h instr=%h", o_pc, o_instr);
            end
         end
      end
   endtask

   task automatic test_pc_wrap();
      logic [31:0] want_addr [3];
      want_addr[0] = 32'hFFFF_FFF8;
      want_addr[1] = 32'hFFFF_FFFC;
      want_addr[2] = 32'h0000_0000;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         i_rst = 1'b0;
         #1;
         if (c < 3) begin
            total++;
            if (w_req !== 1'b1 || w_addr !== want_addr[c]) begin
               bad++;
               $display("FAIL t5_wrap_addr c=%0d got req=%b addr=%h, expected req=1 addr=%h", c, w_req, w_addr, want_addr[c]);
            end else $display("t5 fetch addr=%h", w_addr);
         end else begin
            total++;
            if (w_valid !== 1'b1 || w_pc !== want_addr[c-2] || w_instr !== want_addr[c-2]) begin
               bad++;
               $display("FAIL t5_wrap_head c=%0d got valid=%b pc=%h instr=%h, expected pc=instr=%h", c, w_valid, w_pc, w_instr, want_addr[c-2]);
            end
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] e;
      i_ready = 1'b1;
      do_reset();
      next_cycle();
      i_rst = 1'b0;
      i_redirect = 1'b1;
      i_redirect_pc = 32'h0000_1000;
      load_exp(32'h0000_1000);
      for (int k = 1; k <= 8; k++) begin
         next_cycle();
         i_redirect = 1'b0;
         #1;
         if (k == 3) begin
            total++;
            if (o_valid !== 1'b1 || o_instr !== 32'h33 || o_illegal !== 1'b0) begin
               bad++;
               $display("FAIL t6_legal got valid=%b instr=%h ill=%b, expected instr=00000033 ill=0", o_valid, o_instr, o_illegal);
            end
         end
         if (k == 4) begin
            total++;
            if (o_valid !== 1'b1 || o_instr !== 32'h7F || o_illegal !== ILL_7F) begin
               bad++;
               $display("FAIL t6_illegal got valid=%b instr=%h ill=%b, expected instr=0000007f ill=%b", o_valid, o_instr, o_illegal, ILL_7F);
            end
         end
         if (o_valid && i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL t6_pop got pc=%h, expected no entry", o_pc);
            end else begin
               e = exp_q.pop_front();
               if (o_pc !== e || o_instr !== imem_word(e) || o_illegal !== exp_ill(imem_word(e))) begin
                  bad++;
                  $display("FAIL t6_pop got pc=%h instr=%h ill=%b, expected pc=%h instr=%h ill=%b", o_pc, o_instr, o_illegal, e, imem_word(e), exp_ill(imem_word(e)));
               end else $display("t6 pop pc=%h instr=%h ill=%b", o_pc, o_instr, o_illegal);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] e;
      i_ready = 1'b1;
      do_reset();
      load_exp(32'h0);
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         i_rst = 1'b0;
         #1;
         if (o_valid && i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL t7_pop got pc=%h, expected no entry", o_pc);
            end else begin
               e = exp_q.pop_front();
               if (o_pc !== e || o_instr !== imem_word(e)) begin
                  bad++;
                  $display("FAIL t7_pop got pc=%h instr=%h, expected pc=%h instr=%h", o_pc, o_instr, e, imem_word(e));
               end else $display("t7 pop pc=%h instr=%h", o_pc, o_instr);
            end
         end
      end
      next_cycle();
      i_rst = 1'b1;
      load_exp(32'h0);
      for (int k = 0; k < 12; k++) begin
         next_cycle();
         i_rst = 1'b0;
         #1;
         if (k == 0) begin
            total++;
            if (o_count !== 3'd0 || o_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
               bad++;
               $display("FAIL t7_after_reset got cnt=%0d valid=%b req=%b addr=%h, expected 0 0 1 00000000", o_count, o_valid, o_imem_req, o_imem_addr);
            end
         end
         if (o_valid && i_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL t7_pop got pc=%h, expected no entry", o_pc);
            end else begin
               e = exp_q.pop_front();
               if (o_pc !== e || o_instr !== imem_word(e)) begin
                  bad++;
                  $display("FAIL t7_pop got pc=%h instr=%h, expected pc=%h instr=%h", o_pc, o_instr, e, imem_word(e));
               end else $display("t7 pop pc=%h instr=%h", o_pc, o_instr);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_backpressure();
      test_redirect();
      test_back_to_back();
      test_pc_wrap();
      test_illegal();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
